// File: rtl/easyaxi_mst_wr_data_pkg.sv
// Shared AXI widths, W-channel command record and beat address/strobe/data helpers
// for the EasyAXI write-master W-channel generator.
package easyaxi_mst_wr_data_pkg;

  localparam int AXI_ID_W        = 4;
  localparam int AXI_ADDR_W      = 32;
  localparam int AXI_LEN_W       = 8;
  localparam int AXI_SIZE_W      = 3;
  localparam int AXI_BURST_W     = 2;
  localparam int AXI_DATA_W      = 32;
  localparam int AXI_USER_W      = 8;
  localparam int AXI_WDATA_PAT_W = 32;
  localparam int AXI_STRB_W      = AXI_DATA_W / 8;
  localparam int AXI_STRB_LG     = $clog2(AXI_STRB_W);

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_FIXED = 2'b00;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR  = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP  = 2'b10;

  localparam logic [AXI_ADDR_W-1:0] AXI_ADDR_ONE = 1;

  typedef struct packed {
    logic [AXI_ID_W-1:0]    id;
    logic [AXI_ADDR_W-1:0]  addr;
    logic [AXI_LEN_W-1:0]   len;
    logic [AXI_SIZE_W-1:0]  size;
    logic [AXI_BURST_W-1:0] burst;
  } aw_cmd_t;

  localparam int AW_CMD_W = $bits(aw_cmd_t);

  typedef enum logic [0:0] {
    WD_IDLE = 1'b0,
    WD_DATA = 1'b1
  } wd_state_e;

  function automatic logic [AXI_ADDR_W-1:0] axi_size_bytes(input logic [AXI_SIZE_W-1:0] size);
    return AXI_ADDR_ONE << size;
  endfunction

  function automatic logic [AXI_ADDR_W-1:0] axi_align(input logic [AXI_ADDR_W-1:0] addr,
                                                     input logic [AXI_SIZE_W-1:0] size);
    return addr & ~(axi_size_bytes(size) - AXI_ADDR_ONE);
  endfunction

  // Address of the beat following 'addr'; reserved burst encoding behaves as INCR.
  function automatic logic [AXI_ADDR_W-1:0] axi_next_addr(input logic [AXI_ADDR_W-1:0]  addr,
                                                         input logic [AXI_LEN_W-1:0]   len,
                                                         input logic [AXI_SIZE_W-1:0]  size,
                                                         input logic [AXI_BURST_W-1:0] burst);
    logic [AXI_ADDR_W-1:0] bytes;
    logic [AXI_ADDR_W-1:0] wrap_bytes;
    logic [AXI_ADDR_W-1:0] boundary;
    logic [AXI_ADDR_W-1:0] nxt;
    bytes      = axi_size_bytes(size);
    wrap_bytes = ({{(AXI_ADDR_W-AXI_LEN_W){1'b0}}, len} + AXI_ADDR_ONE) << size;
    boundary   = addr & ~(wrap_bytes - AXI_ADDR_ONE);
    case (burst)
      AXI_BURST_FIXED: nxt = addr;
      AXI_BURST_WRAP:  nxt = boundary + ((addr + bytes) & (wrap_bytes - AXI_ADDR_ONE));
      default:         nxt = axi_align(addr, size) + bytes;
    endcase
    return nxt;
  endfunction

  function automatic logic [AXI_STRB_W-1:0] axi_wstrb(input logic [AXI_ADDR_W-1:0] addr,
                                                     input logic [AXI_SIZE_W-1:0] size);
    logic [AXI_ADDR_W-1:0] al;
    logic [AXI_STRB_W-1:0] s;
    int lo;
    int hi;
    al = axi_align(addr, size);
    lo = int'(addr[AXI_STRB_LG-1:0]);
    hi = int'(al[AXI_STRB_LG-1:0]) + (1 << size) - 1;
    for (int i = 0; i < AXI_STRB_W; i++) begin
      s[i] = (i >= lo) && (i <= hi);
    end
    if (int'(size) >= AXI_STRB_LG) s = '1;
    return s;
  endfunction

  function automatic logic [AXI_WDATA_PAT_W-1:0] axi_wdata_word(input logic [AXI_ID_W-1:0]   id,
                                                               input logic [AXI_LEN_W-1:0]  beat,
                                                               input logic [AXI_ADDR_W-1:0] addr);
    logic [7:0] id8;
    logic [7:0] beat8;
    id8   = 8'(id);
    beat8 = 8'(beat);
    return {id8, beat8, addr[15:0]};
  endfunction

endpackage

// File: rtl/easyaxi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty/count.
module easyaxi_sync_fifo
  import easyaxi_mst_wr_data_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int WIDTH = AW_CMD_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         din_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         dout_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_ONE  = 1;
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             do_wr, do_rd;

  assign full_o  = (count_q == CNT_FULL);
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign do_wr = wr_en_i && !full_o;
  assign do_rd = rd_en_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; only pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/easyaxi_mst_wr_data.sv
// W-channel beat generator: snoops accepted AW commands, queues them in order and
// emits each burst with predictable WDATA/WSTRB/WLAST/WUSER.
module easyaxi_mst_wr_data
  import easyaxi_mst_wr_data_pkg::*;
#(
  parameter int OST_DEPTH = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        axi_mst_awvalid,
  input  logic                        axi_mst_awready,
  input  logic [AXI_ID_W-1:0]         axi_mst_awid,
  input  logic [AXI_ADDR_W-1:0]       axi_mst_awaddr,
  input  logic [AXI_LEN_W-1:0]        axi_mst_awlen,
  input  logic [AXI_SIZE_W-1:0]       axi_mst_awsize,
  input  logic [AXI_BURST_W-1:0]      axi_mst_awburst,
  output logic                        aw_allow,
  output logic                        axi_mst_wvalid,
  input  logic                        axi_mst_wready,
  output logic [AXI_DATA_W-1:0]       axi_mst_wdata,
  output logic [AXI_DATA_W/8-1:0]     axi_mst_wstrb,
  output logic                        axi_mst_wlast,
  output logic [AXI_USER_W-1:0]       axi_mst_wuser,
  output logic [$clog2(OST_DEPTH):0]  ost_cnt,
  output logic                        burst_done,
  output logic                        push_err
);

  localparam int CNT_W = $clog2(OST_DEPTH) + 1;
  localparam logic [CNT_W-1:0]     OST_FULL = CNT_W'(OST_DEPTH);
  localparam logic [AXI_LEN_W-1:0] LEN_ONE  = 1;
  localparam int PAT_REP = AXI_DATA_W / AXI_WDATA_PAT_W;

  wd_state_e state_q, state_d;

  logic [AXI_ID_W-1:0]    act_id_q,    act_id_d;
  logic [AXI_ADDR_W-1:0]  act_addr_q,  act_addr_d;
  logic [AXI_LEN_W-1:0]   act_len_q,   act_len_d;
  logic [AXI_SIZE_W-1:0]  act_size_q,  act_size_d;
  logic [AXI_BURST_W-1:0] act_burst_q, act_burst_d;
  logic [AXI_LEN_W-1:0]   beat_cnt_q,  beat_cnt_d;
  logic                   push_err_q,  push_err_d;
  logic                   burst_done_q, burst_done_d;

  logic           aw_hs, aw_push, w_hs, load, last_beat, in_data;
  aw_cmd_t        aw_cmd, head_cmd;
  logic [AW_CMD_W-1:0] head_bits;
  logic           fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Outstanding credit covers queued plus in-flight bursts, so the write
  // controller can never hold more than OST_DEPTH bursts awaiting W.
  assign in_data  = (state_q == WD_DATA);
  assign ost_cnt  = fifo_count + CNT_W'(in_data);
  assign aw_allow = (ost_cnt < OST_FULL);

  assign aw_hs   = axi_mst_awvalid && axi_mst_awready;
  assign aw_push = aw_hs && aw_allow && !fifo_full;
  assign aw_cmd  = '{id: axi_mst_awid, addr: axi_mst_awaddr, len: axi_mst_awlen,
                     size: axi_mst_awsize, burst: axi_mst_awburst};
  assign head_cmd = aw_cmd_t'(head_bits);

  easyaxi_sync_fifo #(
    .DEPTH (OST_DEPTH),
    .WIDTH (AW_CMD_W)
  ) u_cmd_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en_i (aw_push),
    .din_i   (aw_cmd),
    .rd_en_i (load),
    .dout_o  (head_bits),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign last_beat = (beat_cnt_q == act_len_q);
  assign w_hs      = axi_mst_wvalid && axi_mst_wready;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      WD_IDLE: begin
        if (!fifo_empty) begin
          load    = 1'b1;
          state_d = WD_DATA;
        end
      end
      WD_DATA: begin
        if (w_hs && last_beat) begin
          if (!fifo_empty) load = 1'b1;
          else             state_d = WD_IDLE;
        end
      end
      default: state_d = WD_IDLE;
    endcase
  end

  always_comb begin
    act_id_d     = act_id_q;
    act_addr_d   = act_addr_q;
    act_len_d    = act_len_q;
    act_size_d   = act_size_q;
    act_burst_d  = act_burst_q;
    beat_cnt_d   = beat_cnt_q;
    push_err_d   = push_err_q || (aw_hs && !aw_allow);
    burst_done_d = w_hs && last_beat;
    if (load) begin
      act_id_d    = head_cmd.id;
      act_addr_d  = head_cmd.addr;
      act_len_d   = head_cmd.len;
      act_size_d  = head_cmd.size;
      act_burst_d = head_cmd.burst;
      beat_cnt_d  = '0;
    end else if (w_hs && !last_beat) begin
      beat_cnt_d = beat_cnt_q + LEN_ONE;
      act_addr_d = axi_next_addr(act_addr_q, act_len_q, act_size_q, act_burst_q);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WD_IDLE;
      act_id_q     <= '0;
      act_addr_q   <= '0;
      act_len_q    <= '0;
      act_size_q   <= '0;
      act_burst_q  <= '0;
      beat_cnt_q   <= '0;
      push_err_q   <= 1'b0;
      burst_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      act_id_q     <= act_id_d;
      act_addr_q   <= act_addr_d;
      act_len_q    <= act_len_d;
      act_size_q   <= act_size_d;
      act_burst_q  <= act_burst_d;
      beat_cnt_q   <= beat_cnt_d;
      push_err_q   <= push_err_d;
      burst_done_q <= burst_done_d;
    end
  end

  // Payload is gated so every W output reads zero outside an active burst.
  assign axi_mst_wvalid = in_data;
  assign axi_mst_wlast  = in_data && last_beat;
  assign axi_mst_wstrb  = in_data ? axi_wstrb(act_addr_q, act_size_q) : '0;
  assign axi_mst_wdata  = in_data ? {PAT_REP{axi_wdata_word(act_id_q, beat_cnt_q, act_addr_q)}} : '0;
  assign axi_mst_wuser  = in_data ? AXI_USER_W'(act_id_q) : '0;
  assign burst_done     = burst_done_q;
  assign push_err       = push_err_q;

endmodule

// File: tb/tb_easyaxi_mst_wr_data.sv
// Scoreboard bench for easyaxi_mst_wr_data: stimulus queues expected beats per AW,
// a negedge monitor pops and compares every W handshake and tracks control outputs.
module tb_easyaxi_mst_wr_data;
  import easyaxi_mst_wr_data_pkg::*;

  localparam int OST = 16;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [7:0]  user;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic axi_mst_awvalid, axi_mst_awready;
  logic [AXI_ID_W-1:0]    axi_mst_awid;
  logic [AXI_ADDR_W-1:0]  axi_mst_awaddr;
  logic [AXI_LEN_W-1:0]   axi_mst_awlen;
  logic [AXI_SIZE_W-1:0]  axi_mst_awsize;
  logic [AXI_BURST_W-1:0] axi_mst_awburst;
  logic aw_allow, axi_mst_wvalid, axi_mst_wready, axi_mst_wlast;
  logic [AXI_DATA_W-1:0]   axi_mst_wdata;
  logic [AXI_DATA_W/8-1:0] axi_mst_wstrb;
  logic [AXI_USER_W-1:0]   axi_mst_wuser;
  logic [$clog2(OST):0]    ost_cnt;
  logic burst_done, push_err;

  easyaxi_mst_wr_data #(.OST_DEPTH(OST)) dut (
    .clk(clk), .rst_n(rst_n),
    .axi_mst_awvalid(axi_mst_awvalid), .axi_mst_awready(axi_mst_awready),
    .axi_mst_awid(axi_mst_awid), .axi_mst_awaddr(axi_mst_awaddr),
    .axi_mst_awlen(axi_mst_awlen), .axi_mst_awsize(axi_mst_awsize),
    .axi_mst_awburst(axi_mst_awburst), .aw_allow(aw_allow),
    .axi_mst_wvalid(axi_mst_wvalid), .axi_mst_wready(axi_mst_wready),
    .axi_mst_wdata(axi_mst_wdata), .axi_mst_wstrb(axi_mst_wstrb),
    .axi_mst_wlast(axi_mst_wlast), .axi_mst_wuser(axi_mst_wuser),
    .ost_cnt(ost_cnt), .burst_done(burst_done), .push_err(push_err)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    errs   = 0;
  beat_t exp_q[$];
  int    wr_mode = 0;
  int    popped = 0;
  int    done_seen = 0;

  int    ost_m = 0;
  logic  err_m = 1'b0;
  logic  done_m = 1'b0;
  logic  hold_v = 1'b0;
  logic [31:0] hold_data;
  logic [3:0]  hold_strb;
  logic        hold_last;
  logic [7:0]  hold_user;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Expected beats straight from the AXI burst rules, one beat index at a time.
  function automatic void gen_beats(input logic [3:0] id, input logic [31:0] addr,
                                    input int len, input int size, input logic [1:0] burst);
    longint la, bytes, al, wrap, bnd, a_l;
    la    = addr;
    bytes = longint'(1) << size;
    al    = la - (la % bytes);
    for (int k = 0; k <= len; k++) begin
      beat_t b;
      logic [31:0] a;
      logic [3:0]  s;
      if (burst == AXI_BURST_FIXED) a_l = la;
      else if (burst == AXI_BURST_WRAP) begin
        wrap = longint'(len + 1) * bytes;
        bnd  = la - (la % wrap);
        a_l  = bnd + ((la - bnd + longint'(k) * bytes) % wrap);
      end else a_l = (k == 0) ? la : al + longint'(k) * bytes;
      a = 32'(a_l);
      s = 4'h0;
      if (size >= 2) s = 4'hF;
      else begin
        for (longint bb = a_l; bb < a_l - (a_l % bytes) + bytes; bb++) s[int'(bb % 4)] = 1'b1;
      end
      b.data = {4'h0, id, 8'(k), a[15:0]};
      b.strb = s;
      b.last = (k == len);
      b.user = {4'h0, id};
      exp_q.push_back(b);
    end
  endfunction

  initial begin
    axi_mst_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (wr_mode)
        0: axi_mst_wready = 1'b0;
        1: axi_mst_wready = 1'b1;
        2: axi_mst_wready = 1'($urandom_range(0, 1));
        default: axi_mst_wready = ~axi_mst_wready;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_wvalid", axi_mst_wvalid, 0);
      chk("rst_wlast", axi_mst_wlast, 0);
      chk("rst_aw_allow", aw_allow, 1);
      chk("rst_ost_cnt", ost_cnt, 0);
      chk("rst_push_err", push_err, 0);
      chk("rst_burst_done", burst_done, 0);
      ost_m = 0; err_m = 1'b0; done_m = 1'b0; hold_v = 1'b0;
    end else begin
      logic aw_legit;
      chk("ost_cnt", ost_cnt, ost_m);
      chk("aw_allow", aw_allow, ost_m < OST);
      chk("push_err", push_err, err_m);
      chk("burst_done", burst_done, done_m);
      if (burst_done) done_seen++;
      if (hold_v) begin
        chk("hold_wvalid", axi_mst_wvalid, 1);
        chk("hold_wdata", axi_mst_wdata, hold_data);
        chk("hold_wstrb", axi_mst_wstrb, hold_strb);
        chk("hold_wlast", axi_mst_wlast, hold_last);
        chk("hold_wuser", axi_mst_wuser, hold_user);
      end
      aw_legit = axi_mst_awvalid && axi_mst_awready && (ost_m < OST);
      if (axi_mst_awvalid && axi_mst_awready && !(ost_m < OST)) err_m = 1'b1;
      done_m = 1'b0;
      if (axi_mst_wvalid && axi_mst_wready) begin
        if (exp_q.size() == 0) chk("w_unexpected_beat", 1, 0);
        else begin
          beat_t e;
          e = exp_q.pop_front();
          popped++;
          chk("wdata", axi_mst_wdata, e.data);
          chk("wstrb", axi_mst_wstrb, e.strb);
          chk("wlast", axi_mst_wlast, e.last);
          chk("wuser", axi_mst_wuser, e.user);
          if (e.last) begin
            ost_m--;
            done_m = 1'b1;
          end
        end
      end
      if (aw_legit) ost_m++;
      hold_v    = axi_mst_wvalid && !axi_mst_wready;
      hold_data = axi_mst_wdata;
      hold_strb = axi_mst_wstrb;
      hold_last = axi_mst_wlast;
      hold_user = axi_mst_wuser;
    end
  end

  task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input logic [1:0] burst);
    int n = 0;
    @(posedge clk); #1;
    while (!aw_allow && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    if (!aw_allow) chk("aw_allow_timeout", 0, 1);
    else begin
      axi_mst_awid    = id;
      axi_mst_awaddr  = addr;
      axi_mst_awlen   = 8'(len);
      axi_mst_awsize  = 3'(size);
      axi_mst_awburst = burst;
      axi_mst_awvalid = 1'b1;
      gen_beats(id, addr, len, size, burst);
      @(posedge clk); #1;
      axi_mst_awvalid = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || ost_cnt != 0) && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk("drain_done", (exp_q.size() == 0) && (ost_cnt == 0), 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic send_random(input int maxlen);
    logic [1:0]  burst;
    logic [31:0] addr;
    int len, size;
    burst = 2'($urandom_range(0, 2));
    size  = $urandom_range(0, 2);
    addr  = $urandom();
    if (burst == AXI_BURST_WRAP) begin
      len  = (1 << $urandom_range(1, 3)) - 1;
      addr = addr & ~((32'd1 << size) - 32'd1);
    end else len = $urandom_range(0, maxlen);
    send_aw(4'($urandom_range(0, 15)), addr, len, size, burst);
  endtask

  initial begin
    int p0, d0, n;
    axi_mst_awvalid = 1'b0;
    axi_mst_awready = 1'b1;
    axi_mst_awid = '0; axi_mst_awaddr = '0; axi_mst_awlen = '0;
    axi_mst_awsize = '0; axi_mst_awburst = '0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    wr_mode = 1;
    p0 = popped; d0 = done_seen;
    send_aw(4'd1, 32'h0, 3, 2, AXI_BURST_INCR);
    drain(200);
    chk("t1_beats", popped - p0, 4);
    chk("t1_done_pulses", done_seen - d0, 1);

    send_aw(4'd2, 32'h34, 3, 2, AXI_BURST_WRAP);
    drain(200);

    wr_mode = 3;
    send_aw(4'd3, 32'h30, 3, 2, AXI_BURST_FIXED);
    drain(200);

    wr_mode = 0;
    send_aw(4'd4, 32'h40, 3, 2, AXI_BURST_INCR);
    send_aw(4'd5, 32'h81, 3, 0, AXI_BURST_INCR);
    repeat (4) @(posedge clk);
    @(negedge clk); #1 wr_mode = 1;
    @(posedge clk);
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (axi_mst_wvalid) n++;
    end
    chk("t5_no_bubble", n, 8);
    drain(200);

    wr_mode = 2;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_random(7);
    end
    drain(4000);

    @(negedge clk); #1 wr_mode = 0;
    for (int i = 0; i < OST; i++) send_random(3);
    repeat (3) @(negedge clk);
    chk("t4_ost_full", ost_cnt, OST);
    chk("t4_allow_low", aw_allow, 0);
    @(posedge clk); #1;
    axi_mst_awid = 4'hE; axi_mst_awaddr = 32'hDEAD0000; axi_mst_awvalid = 1'b1;
    @(posedge clk); #1;
    axi_mst_awvalid = 1'b0;
    repeat (2) @(negedge clk);
    chk("t4_push_err", push_err, 1);
    chk("t4_ost_unchanged", ost_cnt, OST);
    wr_mode = 2;
    drain(2000);

    wr_mode = 1;
    send_aw(4'd6, 32'h100, 7, 2, AXI_BURST_INCR);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(axi_mst_wvalid && axi_mst_wdata[23:16] == 8'd2) && n < 50);
    chk("t6_reach_beat2", n < 50, 1);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk("t6_wvalid_async", axi_mst_wvalid, 0);
    chk("t6_wlast_async", axi_mst_wlast, 0);
    chk("t6_ost_zero", ost_cnt, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("t6_allow_after", aw_allow, 1);
    chk("t6_err_cleared", push_err, 0);
    send_aw(4'd7, 32'h200, 1, 1, AXI_BURST_INCR);
    drain(200);

    chk("final_queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
    $fatal(1, "watchdog");
  end

endmodule
